// File: rtl/cache_pkg.sv
// cache_pkg: shared FSM states and widths for the write-back data cache
package cache_pkg;
  localparam int WORD_W = 32;
  localparam int CNT_W = 32;
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, RESPOND} state_t;
endpackage

// File: rtl/cache_burst_ctrl.sv
// cache_burst_ctrl: sequences one line-sized memory burst, one word per mem_ack
module cache_burst_ctrl #(
  parameter int ADDR_W = 32,
  parameter int BLOCK_WORDS = 1,
  parameter int OFW = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              start_we,
  input  logic [ADDR_W-1:0] start_base,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [OFW-1:0]    off,
  output logic              done
);
  logic [ADDR_W-1:0] base;
  assign done = mem_req && mem_ack && off == OFW'(BLOCK_WORDS - 1);
  assign mem_addr = base | (ADDR_W'(off) << 2);
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      off <= '0;
      base <= '0;
    end else if (start) begin
      mem_req <= 1'b1;
      mem_we <= start_we;
      off <= '0;
      base <= start_base;
    end else if (mem_req && mem_ack) begin
      mem_req <= !done;
      mem_we <= mem_we && !done;
      off <= done ? off : off + OFW'(1);
    end
  end
endmodule

// File: rtl/dm_cache_wb.sv
// dm_cache_wb: direct-mapped write-back write-allocate cache; define CACHE_STATS_EN
// to add saturating hit/miss/writeback counters.
module dm_cache_wb
  import cache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINES = 2048,
  parameter int BLOCK_WORDS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  wb_cnt
`endif
);
  localparam int OW = $clog2(BLOCK_WORDS);
  localparam int IW = $clog2(LINES);
  localparam int OFW = OW > 0 ? OW : 1;
  localparam int IXW = IW > 0 ? IW : 1;
  localparam int TW = ADDR_W - 2 - OW - IW;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_r, base;
  logic we_r, kick, kick_n, kick_we, kick_we_n;
  logic [WORD_W-1:0] wd_r;
  logic [WORD_W-1:0] data_mem [LINES][BLOCK_WORDS];
  logic [TW-1:0] tag_mem [LINES];
  logic [LINES-1:0] valid, dirty;
  logic [TW-1:0] c_tag, r_tag;
  logic [IXW-1:0] c_idx, r_idx, op_idx;
  logic [OFW-1:0] c_off, r_off, op_off, b_off, wr_off;
  logic [WORD_W-1:0] op_wd, wr_data;
  logic accept, hit, do_hit, do_op, op_we, fill, wr_en, b_done, fill_done;
  assign c_tag = TW'(cpu_addr >> (2 + OW + IW));
  assign c_idx = IXW'((cpu_addr >> (2 + OW)) & ADDR_W'(LINES - 1));
  assign c_off = OFW'((cpu_addr >> 2) & ADDR_W'(BLOCK_WORDS - 1));
  assign r_tag = TW'(addr_r >> (2 + OW + IW));
  assign r_idx = IXW'((addr_r >> (2 + OW)) & ADDR_W'(LINES - 1));
  assign r_off = OFW'((addr_r >> 2) & ADDR_W'(BLOCK_WORDS - 1));
  assign accept = state == IDLE && cpu_req && !cpu_done;
  assign hit = valid[c_idx] && tag_mem[c_idx] == c_tag;
  assign do_hit = accept && hit;
  // A hit in IDLE and the RESPOND step share one access path
  assign do_op = do_hit || state == RESPOND;
  assign op_idx = state == IDLE ? c_idx : r_idx;
  assign op_off = state == IDLE ? c_off : r_off;
  assign op_we = state == IDLE ? cpu_we : we_r;
  assign op_wd = state == IDLE ? cpu_wdata : wd_r;
  assign fill = state == REFILL && mem_req && mem_ack;
  assign fill_done = state == REFILL && b_done;
  assign wr_en = fill || (do_op && op_we);
  assign wr_off = fill ? b_off : op_off;
  assign wr_data = fill ? mem_rdata : op_wd;
  assign base = (kick_we ? ADDR_W'(tag_mem[r_idx]) << (2 + OW + IW) : ADDR_W'(r_tag) << (2 + OW + IW))
              | (ADDR_W'(r_idx) << (2 + OW));
  assign mem_wdata = mem_we ? data_mem[r_idx][b_off] : '0;
  always_comb begin
    state_n = state;
    kick_n = 1'b0;
    kick_we_n = 1'b0;
    case (state)
      IDLE: if (accept && !hit) begin
        state_n = valid[c_idx] && dirty[c_idx] ? WRITEBACK : REFILL;
        kick_n = 1'b1;
        kick_we_n = valid[c_idx] && dirty[c_idx];
      end
      WRITEBACK: if (b_done) begin
        state_n = REFILL;
        kick_n = 1'b1;
      end
      REFILL: state_n = b_done ? RESPOND : REFILL;
      RESPOND: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
      cpu_done <= 1'b0;
      cpu_rdata <= '0;
      kick <= 1'b0;
      kick_we <= 1'b0;
      addr_r <= '0;
      we_r <= 1'b0;
      wd_r <= '0;
    end else begin
      state <= state_n;
      kick <= kick_n;
      kick_we <= kick_we_n;
      cpu_done <= do_op;
      if (do_op && !op_we) cpu_rdata <= data_mem[op_idx][op_off];
      if (do_op && op_we) dirty[op_idx] <= 1'b1;
      if (accept) begin
        addr_r <= cpu_addr;
        we_r <= cpu_we;
        wd_r <= cpu_wdata;
      end
      if (fill_done) begin
        valid[r_idx] <= 1'b1;
        dirty[r_idx] <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && wr_en) data_mem[op_idx][wr_off] <= wr_data;
    if (!reset && fill_done) tag_mem[r_idx] <= r_tag;
  end
  cache_burst_ctrl #(.ADDR_W(ADDR_W), .BLOCK_WORDS(BLOCK_WORDS), .OFW(OFW)) u_burst (
    .clk(clk),
    .reset(reset),
    .start(kick),
    .start_we(kick_we),
    .start_base(base),
    .mem_ack(mem_ack),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .off(b_off),
    .done(b_done)
  );
`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt <= '0;
      miss_cnt <= '0;
      wb_cnt <= '0;
    end else begin
      if (do_hit && hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
      if (state == RESPOND && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
      if (state == WRITEBACK && b_done && wb_cnt != '1) wb_cnt <= wb_cnt + CNT_W'(1);
    end
  end
`endif
endmodule
